// File: rtl/systolic_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : systolic_sequencer
//  Purpose  : Sequences one C = A x B product on the output-stationary
//             systolic array: clears the PE accumulators, then streams the
//             skewed A rows into the left edge and B columns into the top
//             edge, and reports completion to the APB slave.
//  Revision : 1.0  initial release
// ============================================================================
module systolic_sequencer #(
    parameter  int DW      = 8,
    parameter  int BW      = 32,
    parameter  int MAX_DIM = BW / DW,
    parameter  int PE_LAT  = 1,
    localparam int IW      = $clog2(MAX_DIM)
) (
    input  logic                  clk_i,
    input  logic                  reset_ni,
    input  logic                  start_i,
    input  logic [IW-1:0]         dim_n_i,
    input  logic [IW-1:0]         dim_k_i,
    input  logic [IW-1:0]         dim_m_i,
    input  logic [BW*MAX_DIM-1:0] operand_a_i,
    input  logic [BW*MAX_DIM-1:0] operand_b_i,
    output logic [DW*MAX_DIM-1:0] a_feed_o,
    output logic [DW*MAX_DIM-1:0] b_feed_o,
    output logic                  clear_o,
    output logic                  busy_o,
    output logic                  done_o
);

    // Largest possible T_LAST sizes the run counter; one extra bit lets the
    // skew subtraction go negative without wrapping into the window.
    localparam int TLAST_MAX = 3 * (MAX_DIM - 1) + PE_LAT;
    localparam int TW        = $clog2(TLAST_MAX + 1);
    localparam int XW        = TW + 1;
    localparam int FW        = DW * MAX_DIM;
    localparam int OW        = BW * MAX_DIM;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_CLEAR = 2'd1,
        S_RUN   = 2'd2,
        S_DONE  = 2'd3
    } state_e;

    state_e          state_q, state_d;
    logic [TW-1:0]   t_q, t_d;
    logic [TW-1:0]   t_last;

    // Snapshot of the command taken on the start edge
    logic [IW-1:0]   dim_n_q, dim_k_q, dim_m_q;
    logic [IW-1:0]   dim_n_d, dim_k_d, dim_m_d;
    logic [OW-1:0]   op_a_q, op_b_q;
    logic [OW-1:0]   op_a_d, op_b_d;

    // Registered outputs
    logic [FW-1:0]   a_feed_q, a_feed_d;
    logic [FW-1:0]   b_feed_q, b_feed_d;
    logic            clear_q, clear_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;

    assign t_last = TW'(dim_k_q) + TW'(dim_n_q) + TW'(dim_m_q) + TW'(PE_LAT);

    // Next-state, run counter and status flags
    always_comb begin
        state_d = state_q;
        t_d     = t_q;
        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    state_d = S_CLEAR;
                end
            end
            S_CLEAR: begin
                if (!start_i) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_RUN;
                    t_d     = '0;
                end
            end
            S_RUN: begin
                if (!start_i) begin
                    state_d = S_IDLE;
                end else if (t_q < t_last) begin
                    t_d = t_q + TW'(1);
                end else begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                if (!start_i) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        // Counter parks at zero outside RUN so every run starts from a known value
        if (state_d != S_RUN) begin
            t_d = '0;
        end
        clear_d = (state_d == S_CLEAR);
        busy_d  = (state_d == S_CLEAR) || (state_d == S_RUN);
        done_d  = (state_d == S_DONE);
    end

    // Snapshot capture only on the IDLE start edge
    always_comb begin
        dim_n_d = dim_n_q;
        dim_k_d = dim_k_q;
        dim_m_d = dim_m_q;
        op_a_d  = op_a_q;
        op_b_d  = op_b_q;
        if ((state_q == S_IDLE) && start_i) begin
            dim_n_d = dim_n_i;
            dim_k_d = dim_k_i;
            dim_m_d = dim_m_i;
            op_a_d  = operand_a_i;
            op_b_d  = operand_b_i;
        end
    end

    // Skewed feed selection for the cycle about to be entered (t_d), so the
    // feed registers present the element for RUN cycle t exactly while t_q == t
    always_comb begin
        logic [XW-1:0] tx;
        logic [XW-1:0] lane;
        logic [XW-1:0] diff;
        a_feed_d = '0;
        b_feed_d = '0;
        tx       = {1'b0, t_d};
        lane     = '0;
        diff     = '0;
        if (state_d == S_RUN) begin
            for (int r = 0; r < MAX_DIM; r++) begin
                lane = XW'(r);
                diff = tx - lane;
                if ((lane <= XW'(dim_n_q)) && (tx >= lane) && (diff <= XW'(dim_k_q))) begin
                    for (int kk = 0; kk < MAX_DIM; kk++) begin
                        if (diff == XW'(kk)) begin
                            a_feed_d[DW*r +: DW] = op_a_q[BW*r + DW*kk +: DW];
                        end
                    end
                end
            end
            for (int c = 0; c < MAX_DIM; c++) begin
                lane = XW'(c);
                diff = tx - lane;
                if ((lane <= XW'(dim_m_q)) && (tx >= lane) && (diff <= XW'(dim_k_q))) begin
                    for (int kk = 0; kk < MAX_DIM; kk++) begin
                        if (diff == XW'(kk)) begin
                            b_feed_d[DW*c +: DW] = op_b_q[BW*kk + DW*c +: DW];
                        end
                    end
                end
            end
        end
    end

    // State, counter and output registers
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q  <= S_IDLE;
            t_q      <= '0;
            a_feed_q <= '0;
            b_feed_q <= '0;
            clear_q  <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            t_q      <= t_d;
            a_feed_q <= a_feed_d;
            b_feed_q <= b_feed_d;
            clear_q  <= clear_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    // Snapshot registers
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            dim_n_q <= '0;
            dim_k_q <= '0;
            dim_m_q <= '0;
            op_a_q  <= '0;
            op_b_q  <= '0;
        end else begin
            dim_n_q <= dim_n_d;
            dim_k_q <= dim_k_d;
            dim_m_q <= dim_m_d;
            op_a_q  <= op_a_d;
            op_b_q  <= op_b_d;
        end
    end

    assign a_feed_o = a_feed_q;
    assign b_feed_o = b_feed_q;
    assign clear_o  = clear_q;
    assign busy_o   = busy_q;
    assign done_o   = done_q;

endmodule
`default_nettype wire

// File: tb/tb_systolic_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_systolic_sequencer
//  Purpose  : Directed/randomized self-checking bench for systolic_sequencer.
//             Expected feeds come from the skew rule applied to the matrices,
//             and the final product from plain matrix arithmetic.
//  Revision : 1.0  initial release
// ============================================================================
module tb_systolic_sequencer;

    localparam int DW     = 8;
    localparam int BW     = 32;
    localparam int MD     = 4;
    localparam int PE_LAT = 1;
    localparam int IW     = 2;
    localparam int FW     = DW * MD;

    logic              clk = 1'b0;
    logic              reset_ni = 1'b0;
    logic              start_i = 1'b0;
    logic [IW-1:0]     dim_n_i = '0;
    logic [IW-1:0]     dim_k_i = '0;
    logic [IW-1:0]     dim_m_i = '0;
    logic [BW*MD-1:0]  operand_a_i = '0;
    logic [BW*MD-1:0]  operand_b_i = '0;
    logic [FW-1:0]     a_feed_o;
    logic [FW-1:0]     b_feed_o;
    logic              clear_o;
    logic              busy_o;
    logic              done_o;

    int checks = 0;
    int errors = 0;

    int A   [MD][MD];
    int B   [MD][MD];
    int acc [MD][MD];
    int ar  [MD][MD];
    int br  [MD][MD];

    systolic_sequencer #(
        .DW      (DW),
        .BW      (BW),
        .MAX_DIM (MD),
        .PE_LAT  (PE_LAT)
    ) dut (
        .clk_i       (clk),
        .reset_ni    (reset_ni),
        .start_i     (start_i),
        .dim_n_i     (dim_n_i),
        .dim_k_i     (dim_k_i),
        .dim_m_i     (dim_m_i),
        .operand_a_i (operand_a_i),
        .operand_b_i (operand_b_i),
        .a_feed_o    (a_feed_o),
        .b_feed_o    (b_feed_o),
        .clear_o     (clear_o),
        .busy_o      (busy_o),
        .done_o      (done_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_quiet(input string tag, input logic exp_done);
        chk({tag, ".a_feed"}, a_feed_o, '0);
        chk({tag, ".b_feed"}, b_feed_o, '0);
        chk({tag, ".clear"},  clear_o, 1'b0);
        chk({tag, ".busy"},   busy_o,  1'b0);
        chk({tag, ".done"},   done_o,  exp_done);
    endtask

    // Expected left-edge word: lane r carries A[r][t-r] inside the window
    function automatic logic [FW-1:0] exp_a(input int t, input int n, input int k);
        logic [FW-1:0] v;
        v = '0;
        for (int r = 0; r < MD; r++)
            if (r < n && t - r >= 0 && t - r < k) v[DW*r +: DW] = DW'(A[r][t-r]);
        return v;
    endfunction

    // Expected top-edge word: lane c carries B[t-c][c] inside the window
    function automatic logic [FW-1:0] exp_b(input int t, input int m, input int k);
        logic [FW-1:0] v;
        v = '0;
        for (int c = 0; c < MD; c++)
            if (c < m && t - c >= 0 && t - c < k) v[DW*c +: DW] = DW'(B[t-c][c]);
        return v;
    endfunction

    task automatic randomize_mats();
        for (int i = 0; i < MD; i++)
            for (int j = 0; j < MD; j++) begin
                A[i][j] = int'($urandom_range(0, 255));
                B[i][j] = int'($urandom_range(0, 255));
            end
    endtask

    task automatic load_ops();
        for (int i = 0; i < MD; i++)
            for (int j = 0; j < MD; j++) begin
                operand_a_i[BW*i + DW*j +: DW] = DW'(A[i][j]);
                operand_b_i[BW*i + DW*j +: DW] = DW'(B[i][j]);
            end
    endtask

    task automatic pe_clear();
        for (int i = 0; i < MD; i++)
            for (int j = 0; j < MD; j++) begin
                acc[i][j] = 0;
                ar[i][j]  = 0;
                br[i][j]  = 0;
            end
    endtask

    // Output-stationary PE grid fed by the DUT's edge streams
    task automatic pe_tick(input logic [FW-1:0] af, input logic [FW-1:0] bf);
        int na [MD][MD];
        int nb [MD][MD];
        for (int r = 0; r < MD; r++)
            for (int c = 0; c < MD; c++) begin
                na[r][c] = (c == 0) ? int'(af[DW*r +: DW]) : ar[r][c-1];
                nb[r][c] = (r == 0) ? int'(bf[DW*c +: DW]) : br[r-1][c];
                acc[r][c] += na[r][c] * nb[r][c];
            end
        ar = na;
        br = nb;
    endtask

    // One complete command; abort_t / reset_t >= 0 cut the run at that RUN cycle
    task automatic run(input int n, input int k, input int m,
                       input int abort_t, input int reset_t, input int hold);
        int tl;
        int ref_c;
        tl = (n - 1) + (k - 1) + (m - 1) + PE_LAT;
        load_ops();
        dim_n_i = IW'(n - 1);
        dim_k_i = IW'(k - 1);
        dim_m_i = IW'(m - 1);
        start_i = 1'b1;
        step();
        chk("clear.pulse", clear_o, 1'b1);
        chk("clear.busy",  busy_o,  1'b1);
        chk("clear.done",  done_o,  1'b0);
        chk("clear.feeds", {a_feed_o, b_feed_o}, '0);
        if (clear_o) pe_clear();
        // Inputs after the start edge must not matter
        operand_a_i = {$urandom, $urandom, $urandom, $urandom};
        operand_b_i = {$urandom, $urandom, $urandom, $urandom};
        dim_n_i     = IW'($urandom);
        dim_k_i     = IW'($urandom);
        dim_m_i     = IW'($urandom);
        for (int t = 0; t <= tl; t++) begin
            step();
            chk("run.a_feed", a_feed_o, exp_a(t, n, k));
            chk("run.b_feed", b_feed_o, exp_b(t, m, k));
            chk("run.busy",   busy_o,  1'b1);
            chk("run.clear",  clear_o, 1'b0);
            chk("run.done",   done_o,  1'b0);
            pe_tick(a_feed_o, b_feed_o);
            if (t == abort_t) begin
                start_i = 1'b0;
                step();
                chk_quiet("abort", 1'b0);
                repeat (3) begin
                    step();
                    chk_quiet("abort.idle", 1'b0);
                end
                return;
            end
            if (t == reset_t) begin
                #2;
                reset_ni = 1'b0;
                #1;
                chk_quiet("async_reset", 1'b0);
                step();
                chk_quiet("reset_hold", 1'b0);
                #3;
                reset_ni = 1'b1;
                return;
            end
        end
        step();
        chk_quiet("done.rise", 1'b1);
        for (int r = 0; r < n; r++)
            for (int c = 0; c < m; c++) begin
                ref_c = 0;
                for (int kk = 0; kk < k; kk++) ref_c += A[r][kk] * B[kk][c];
                chk("product.C", 64'(acc[r][c]), 64'(ref_c));
            end
        for (int h = 0; h < hold; h++) begin
            step();
            chk_quiet("done.hold", 1'b1);
        end
        start_i = 1'b0;
        step();
        chk_quiet("done.fall", 1'b0);
    endtask

    initial begin
        // Reset held with random inputs
        reset_ni = 1'b0;
        for (int i = 0; i < 4; i++) begin
            start_i     = 1'($urandom);
            dim_n_i     = IW'($urandom);
            dim_k_i     = IW'($urandom);
            dim_m_i     = IW'($urandom);
            operand_a_i = {$urandom, $urandom, $urandom, $urandom};
            operand_b_i = {$urandom, $urandom, $urandom, $urandom};
            #7;
            chk_quiet("reset.held", 1'b0);
        end
        start_i = 1'b0;
        #3;
        reset_ni = 1'b1;
        repeat (3) begin
            step();
            chk_quiet("reset.release", 1'b0);
        end

        // 4x4x4, identity A, B = 1..16
        for (int i = 0; i < MD; i++)
            for (int j = 0; j < MD; j++) begin
                A[i][j] = (i == j) ? 1 : 0;
                B[i][j] = i * MD + j + 1;
            end
        run(4, 4, 4, -1, -1, 0);

        // N=2, K=3, M=1
        randomize_mats();
        run(2, 3, 1, -1, -1, 0);

        // Abort at RUN t=3, then a clean run
        randomize_mats();
        run(4, 4, 4, 3, -1, 0);
        randomize_mats();
        run(3, 2, 4, -1, -1, 0);

        // Done held 20 cycles under start_i=1
        randomize_mats();
        run(2, 2, 2, -1, -1, 20);

        // Smallest case
        randomize_mats();
        run(1, 1, 1, -1, -1, 2);

        // Async reset at RUN t=5, then a fresh full run with start still high
        randomize_mats();
        run(4, 4, 4, -1, 5, 0);
        randomize_mats();
        run(4, 4, 4, -1, -1, 0);

        // Random shapes
        for (int i = 0; i < 8; i++) begin
            randomize_mats();
            run(int'($urandom_range(1, MD)), int'($urandom_range(1, MD)),
                int'($urandom_range(1, MD)), -1, -1, int'($urandom_range(0, 3)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
